// File: rtl/fe_sweep_sequencer.sv
// fe_sweep_sequencer
//
// Steps the RF front end through a programmable table of up to eight
// switch/filter configurations. For each entry it applies the configuration,
// waits a settle time with rx disabled, then enables rx for a programmed
// number of halfband output samples. It is programmed over the serial
// setting bus and runs in the adcclk domain.
//
// Ports:
//   clock          adcclk domain clock
//   reset_n        synchronous reset, active low
//   serial_addr    setting bus address
//   serial_data    setting bus data
//   serial_strobe  setting bus write strobe (one cycle)
//   sample_strobe  hb_strobe from rx_chain, one pulse per output sample
//   fe_ctrl        {FILTER_A1, FILTER_A0, VSWD, VSWC, VSWB, VSWA} of current entry
//   enable_rx      rx enable, high only while dwelling
//   entry_idx      index of the entry currently applied
//   busy           high whenever the sequencer is not idle
//   sweep_done     one-cycle pulse when the last entry's dwell completes
//   status         {sweep_count, 8'h0, busy, entry_idx, 1'b0, state}
//
// Register map (relative to BASE_ADDR):
//   +0 CTRL   bit0 start, bit1 loop, bit2 abort, bits[6:4] last_idx
//   +1 SETTLE settle cycles
//   +2 DWELL  dwell sample strobes (0 behaves as 1)
//   +3 TABLE  bits[18:16] entry index, bits[5:0] entry config

`timescale 1ns/1ps

module fe_sweep_sequencer #(
    parameter logic [6:0] BASE_ADDR = 7'd80,
    parameter int          SETTLE_W  = 16,
    parameter int          DWELL_W   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        sample_strobe,
    output logic [5:0]  fe_ctrl,
    output logic        enable_rx,
    output logic [2:0]  entry_idx,
    output logic        busy,
    output logic        sweep_done,
    output logic [31:0] status
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    state_t              state;

    // Programmed configuration
    logic                ctrl_loop;
    logic [2:0]          last_idx;
    logic [SETTLE_W-1:0] settle_reg;
    logic [DWELL_W-1:0]  dwell_reg;
    logic [5:0]          table_mem [8];

    // Self-clearing events captured from a CTRL write
    logic                start_pend;
    logic                abort_pend;

    // Working counters
    logic [SETTLE_W-1:0] settle_cnt;
    logic [DWELL_W-1:0]  dwell_left;
    logic [15:0]         sweep_count;

    logic                wr_ctrl;
    logic                wr_settle;
    logic                wr_dwell;
    logic                wr_table;
    logic                unused_data;

    // A dwell length of zero still needs one sample to terminate the entry.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] v);
        return (v == '0) ? DWELL_W'(1) : v;
    endfunction

    assign wr_ctrl   = serial_strobe && (serial_addr == BASE_ADDR);
    assign wr_settle = serial_strobe && (serial_addr == BASE_ADDR + 7'd1);
    assign wr_dwell  = serial_strobe && (serial_addr == BASE_ADDR + 7'd2);
    assign wr_table  = serial_strobe && (serial_addr == BASE_ADDR + 7'd3);

    assign unused_data = ^serial_data[31:19];

    assign busy   = (state != S_IDLE);
    assign status = {sweep_count, 8'd0, busy, entry_idx, 1'b0, state};

    // Register file. Start is only captured while idle so a start issued
    // during a sweep can neither restart it nor clear sweep_count. A write
    // carrying both start and abort captures only the abort.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl_loop  <= 1'b0;
            last_idx   <= 3'd0;
            settle_reg <= '0;
            dwell_reg  <= '0;
            start_pend <= 1'b0;
            abort_pend <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                table_mem[i] <= 6'd0;
            end
        end else begin
            start_pend <= wr_ctrl && serial_data[0] && !serial_data[2] && (state == S_IDLE);
            abort_pend <= wr_ctrl && serial_data[2];
            if (wr_ctrl) begin
                ctrl_loop <= serial_data[1];
                last_idx  <= serial_data[6:4];
            end
            if (wr_settle) begin
                settle_reg <= serial_data[SETTLE_W-1:0];
            end
            if (wr_dwell) begin
                dwell_reg <= serial_data[DWELL_W-1:0];
            end
            if (wr_table) begin
                table_mem[serial_data[18:16]] <= serial_data[5:0];
            end
        end
    end

    // Sequencer. fe_ctrl is only ever loaded on the edge entering APPLY, so
    // table writes never disturb the configuration of an entry in progress.
    // The last-entry decision is taken on the edge leaving DWELL and held in
    // sweep_done, which NEXT then uses to choose between wrap/idle and advance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fe_ctrl     <= 6'd0;
            enable_rx   <= 1'b0;
            entry_idx   <= 3'd0;
            sweep_done  <= 1'b0;
            sweep_count <= 16'd0;
            settle_cnt  <= '0;
            dwell_left  <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (abort_pend) begin
                state     <= S_IDLE;
                enable_rx <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_pend) begin
                            state       <= S_APPLY;
                            entry_idx   <= 3'd0;
                            sweep_count <= 16'd0;
                            fe_ctrl     <= table_mem[0];
                        end
                    end
                    S_APPLY: begin
                        if (settle_reg == '0) begin
                            state      <= S_DWELL;
                            enable_rx  <= 1'b1;
                            dwell_left <= dwell_load(dwell_reg);
                        end else begin
                            state      <= S_SETTLE;
                            settle_cnt <= settle_reg;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt <= SETTLE_W'(1)) begin
                            state      <= S_DWELL;
                            enable_rx  <= 1'b1;
                            dwell_left <= dwell_load(dwell_reg);
                        end else begin
                            settle_cnt <= settle_cnt - SETTLE_W'(1);
                        end
                    end
                    S_DWELL: begin
                        if (sample_strobe) begin
                            if (dwell_left <= DWELL_W'(1)) begin
                                state     <= S_NEXT;
                                enable_rx <= 1'b0;
                                // A last_idx lowered below the current entry
                                // still ends the sweep here.
                                if (entry_idx >= last_idx) begin
                                    sweep_done  <= 1'b1;
                                    sweep_count <= sweep_count + 16'd1;
                                end
                            end else begin
                                dwell_left <= dwell_left - DWELL_W'(1);
                            end
                        end
                    end
                    S_NEXT: begin
                        if (sweep_done) begin
                            if (ctrl_loop) begin
                                state     <= S_APPLY;
                                entry_idx <= 3'd0;
                                fe_ctrl   <= table_mem[0];
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            state     <= S_APPLY;
                            entry_idx <= entry_idx + 3'd1;
                            fe_ctrl   <= table_mem[entry_idx + 3'd1];
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        enable_rx <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fe_sweep_sequencer.sv
// Testbench for fe_sweep_sequencer. Stimulus programs the block and pushes
// the expected per-entry behaviour (config, index, settle cycles, strobes
// dwelt) and expected sweep_done counts into queues; a monitor measures each
// dwell segment and each sweep_done pulse from the outputs and compares.

`timescale 1ns/1ps

module tb_fe_sweep_sequencer;

    localparam logic [6:0] BASE = 7'd80;

    logic        clock         = 1'b0;
    logic        reset_n       = 1'b0;
    logic [6:0]  serial_addr   = 7'd0;
    logic [31:0] serial_data   = 32'd0;
    logic        serial_strobe = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [5:0]  fe_ctrl;
    logic        enable_rx;
    logic [2:0]  entry_idx;
    logic        busy;
    logic        sweep_done;
    logic [31:0] status;

    fe_sweep_sequencer #(
        .BASE_ADDR(BASE),
        .SETTLE_W (16),
        .DWELL_W  (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .serial_addr  (serial_addr),
        .serial_data  (serial_data),
        .serial_strobe(serial_strobe),
        .sample_strobe(sample_strobe),
        .fe_ctrl      (fe_ctrl),
        .enable_rx    (enable_rx),
        .entry_idx    (entry_idx),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .status       (status)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] fe;
        logic [2:0] idx;
        int         settle;
        int         strobes;
    } seg_t;

    seg_t exp_seg[$];
    int   exp_done[$];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample strobe generator: one pulse every strb_period cycles (0 = off)
    int strb_period = 0;
    int strb_ctr    = 0;

    always @(posedge clock) begin
        #1;
        strb_ctr = strb_ctr + 1;
        if (strb_period != 0 && strb_ctr >= strb_period) begin
            sample_strobe = 1'b1;
            strb_ctr      = 0;
        end else begin
            sample_strobe = 1'b0;
        end
    end

    // Monitor
    logic       prev_en     = 1'b0;
    int         settle_cyc  = 0;
    int         strobe_cnt  = 0;
    int         idle_cycles = 0;
    int         done_seen   = 0;
    logic [5:0] cur_fe      = 6'd0;
    logic [2:0] cur_idx     = 3'd0;
    int         cur_settle  = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_en    = 1'b0;
            settle_cyc = 0;
            strobe_cnt = 0;
        end else begin
            if (status[2:0] == 3'd1) settle_cyc = 0;
            if (status[2:0] == 3'd2) settle_cyc = settle_cyc + 1;
            if (enable_rx && !prev_en) begin
                cur_fe     = fe_ctrl;
                cur_idx    = entry_idx;
                cur_settle = settle_cyc;
                strobe_cnt = 0;
            end
            if (!enable_rx && prev_en) begin
                check("seg_expected", {31'd0, exp_seg.size() > 0}, 32'd1);
                if (exp_seg.size() > 0) begin
                    seg_t e;
                    e = exp_seg.pop_front();
                    check("seg_fe_ctrl", {26'd0, cur_fe}, {26'd0, e.fe});
                    check("seg_entry_idx", {29'd0, cur_idx}, {29'd0, e.idx});
                    check("seg_settle_cycles", cur_settle, e.settle);
                    check("seg_strobes", strobe_cnt, e.strobes);
                end
            end
            if (enable_rx && sample_strobe) strobe_cnt = strobe_cnt + 1;
            if (sweep_done) begin
                done_seen = done_seen + 1;
                check("done_expected", {31'd0, exp_done.size() > 0}, 32'd1);
                if (exp_done.size() > 0) begin
                    int c;
                    c = exp_done.pop_front();
                    check("done_sweep_count", {16'd0, status[31:16]}, c);
                    check("done_state_next", {29'd0, status[2:0]}, 32'd4);
                end
            end
            if (!busy) idle_cycles = idle_cycles + 1;
            prev_en = enable_rx;
        end
    end

    task automatic write_reg(input logic [6:0] addr, input logic [31:0] data);
        @(posedge clock);
        #1;
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        @(posedge clock);
        #1;
        serial_strobe = 1'b0;
        serial_data   = 32'd0;
    endtask

    task automatic program_table(input logic [5:0] v0, input logic [5:0] v1, input logic [5:0] v2);
        write_reg(BASE + 7'd3, {13'd0, 3'd0, 10'd0, v0});
        write_reg(BASE + 7'd3, {13'd0, 3'd1, 10'd0, v1});
        write_reg(BASE + 7'd3, {13'd0, 3'd2, 10'd0, v2});
    endtask

    task automatic push_seg(input logic [5:0] fe, input logic [2:0] idx, input int s, input int d);
        seg_t e;
        e.fe      = fe;
        e.idx     = idx;
        e.settle  = s;
        e.strobes = d;
        exp_seg.push_back(e);
    endtask

    task automatic push_pass3();
        push_seg(6'h01, 3'd0, 5, 4);
        push_seg(6'h12, 3'd1, 5, 4);
        push_seg(6'h2C, 3'd2, 5, 4);
    endtask

    task automatic start_sweep(input logic [31:0] ctrl);
        write_reg(BASE, ctrl);
        @(posedge clock);
        #1;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_state_apply", {29'd0, status[2:0]}, 32'd1);
        check("start_entry0", {29'd0, entry_idx}, 32'd0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(input int count, input int budget, input string name);
        int n;
        n = 0;
        while (done_seen < count && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, done_seen, count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_at_first;
        int n;

        // Reset and readback
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_status", status, 32'd0);
        check("reset_fe_ctrl", {26'd0, fe_ctrl}, 32'd0);
        check("reset_enable_rx", {31'd0, enable_rx}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_sweep_done", {31'd0, sweep_done}, 32'd0);
        reset_n = 1'b1;

        // Writes outside the register window do nothing
        write_reg(BASE + 7'd4, 32'hFFFF_FFFF);
        write_reg(BASE - 7'd1, 32'h0000_0001);
        repeat (2) @(posedge clock);
        #1;
        check("foreign_addr_status", status, 32'd0);

        // Single pass over three entries
        program_table(6'h01, 6'h12, 6'h2C);
        write_reg(BASE + 7'd1, 32'd5);
        write_reg(BASE + 7'd2, 32'd4);
        strb_period = 3;
        push_pass3();
        exp_done.push_back(1);
        start_sweep(32'h0000_0021);
        wait_idle(400, "single_pass_idle");
        check("single_pass_status", status, 32'h0001_0020);
        check("single_pass_fe_held", {26'd0, fe_ctrl}, 32'h2C);
        check("single_pass_rx_off", {31'd0, enable_rx}, 32'd0);

        // Loop mode over entries 0..1, three sweeps, then abort
        for (int i = 0; i < 3; i++) begin
            push_seg(6'h01, 3'd0, 5, 4);
            push_seg(6'h12, 3'd1, 5, 4);
            exp_done.push_back(i + 1);
        end
        done_seen = 0;
        start_sweep(32'h0000_0013);
        wait_done(1, 400, "loop_first_done");
        idle_at_first = idle_cycles;
        wait_done(3, 800, "loop_third_done");
        check("loop_no_idle_gap", idle_cycles, idle_at_first);
        write_reg(BASE, 32'h0000_0014);
        wait_idle(20, "loop_abort_idle");
        check("loop_sweep_count", {16'd0, status[31:16]}, 32'd3);
        check("loop_entry_wrapped", {29'd0, entry_idx}, 32'd0);

        // Zero settle, zero dwell
        write_reg(BASE + 7'd1, 32'd0);
        write_reg(BASE + 7'd2, 32'd0);
        push_seg(6'h01, 3'd0, 0, 1);
        exp_done.push_back(1);
        start_sweep(32'h0000_0001);
        @(posedge clock);
        #1;
        check("zero_settle_direct_dwell", {29'd0, status[2:0]}, 32'd3);
        wait_idle(100, "zero_idle");
        check("zero_status", status, 32'h0001_0000);

        // Abort mid-dwell after 2 of 4 strobes
        write_reg(BASE + 7'd1, 32'd5);
        write_reg(BASE + 7'd2, 32'd4);
        strb_period = 6;
        push_seg(6'h01, 3'd0, 5, 2);
        start_sweep(32'h0000_0021);
        n = 0;
        while (!(prev_en && strobe_cnt == 2) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("abort_reached_two_strobes", strobe_cnt, 32'd2);
        write_reg(BASE, 32'h0000_0024);
        check("abort_rx_before_edge", {31'd0, enable_rx}, 32'd1);
        @(posedge clock);
        #1;
        check("abort_rx_off", {31'd0, enable_rx}, 32'd0);
        check("abort_state_idle", {29'd0, status[2:0]}, 32'd0);
        check("abort_fe_held", {26'd0, fe_ctrl}, 32'h01);
        check("abort_entry_held", {29'd0, entry_idx}, 32'd0);
        check("abort_count", {16'd0, status[31:16]}, 32'd0);
        repeat (3) @(posedge clock);

        // Restart after abort begins at entry 0
        strb_period = 3;
        push_pass3();
        exp_done.push_back(1);
        start_sweep(32'h0000_0021);
        wait_idle(400, "restart_idle");
        check("restart_status", status, 32'h0001_0020);

        // Reset while settling
        start_sweep(32'h0000_0021);
        n = 0;
        while (status[2:0] != 3'd2 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reached_settle", {29'd0, status[2:0]}, 32'd2);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_status", status, 32'd0);
        check("rst_mid_fe_ctrl", {26'd0, fe_ctrl}, 32'd0);
        check("rst_mid_enable_rx", {31'd0, enable_rx}, 32'd0);
        check("rst_mid_sweep_done", {31'd0, sweep_done}, 32'd0);
        reset_n = 1'b1;

        // Registers were cleared by reset: table 0, settle 0, dwell behaves as 1
        push_seg(6'h00, 3'd0, 0, 1);
        exp_done.push_back(1);
        start_sweep(32'h0000_0001);
        wait_idle(100, "cleared_regs_idle");

        // Start while busy is ignored
        program_table(6'h01, 6'h12, 6'h2C);
        write_reg(BASE + 7'd1, 32'd5);
        write_reg(BASE + 7'd2, 32'd4);
        push_pass3();
        exp_done.push_back(1);
        start_sweep(32'h0000_0021);
        n = 0;
        while (!(status[2:0] == 3'd3 && entry_idx == 3'd1) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("retrig_in_entry1", {29'd0, entry_idx}, 32'd1);
        write_reg(BASE, 32'h0000_0021);
        @(posedge clock);
        #1;
        check("retrig_entry_kept", {29'd0, entry_idx}, 32'd1);
        check("retrig_still_busy", {31'd0, busy}, 32'd1);
        wait_idle(400, "retrig_idle");
        check("retrig_status", status, 32'h0001_0020);

        repeat (2) @(posedge clock);
        check("seg_queue_drained", exp_seg.size(), 32'd0);
        check("done_queue_drained", exp_done.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
